regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port architectural register file; successor to the single-write, two-read 64x32 file.
- Configurable width, depth, read-port count and write-port count.
- Adds a hardwired zero register, same-cycle write-to-read bypass, a pending-write scoreboard, and a post-reset clearing sweep.
- Sits in the decode/register-read stage; writeback ports drive it, operand-fetch logic reads it.

Parameters:
WIDTH, 64, data bits per register
DEPTH, 32, number of registers (power of 2, >=4)
NRD, 2, read ports
NWR, 2, write ports
ZERO_REG, 1, 1 = register DEPTH-1 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*WIDTH  read data, combinational
rd_pending  out  NRD  addressed register awaits a scoreboarded write
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*WIDTH  write data
sb_set  in  1  mark sb_addr pending (producer issued)
sb_addr  in  AW  scoreboard address
init_done  out  1  high once the clearing sweep has completed

Behaviour:
- FSM states: RF_INIT, RF_RUN.
  - rst=1 at posedge: state<=RF_INIT, sweep counter<=0, all pending bits<=0.
  - In RF_INIT: mem[cnt]<=0 each cycle and cnt increments; cnt==DEPTH-1 -> RF_RUN on the next edge.
  - Sweep takes exactly DEPTH cycles after rst falls.
  - rst reasserted mid-sweep restarts the sweep from 0.
- init_done: 0 in RF_INIT, 1 in RF_RUN. Reset value 0.
- While init_done=0:
  - rd_data = 0, rd_pending = 0.
  - wr_en and sb_set are ignored; the upstream stage must stall.
- Storage: plain array without reset, so it maps to RAM/latches. Zeroing comes only from the sweep.
- Write: for each port j with wr_en[j] in RF_RUN, mem[wr_addr[j]]<=wr_data[j] at posedge. Committed data is readable from the array from the next cycle.
- Write conflict: two enabled ports with the same address -> highest-index port wins; the other write is dropped.
- Read:
  - rd_data[i] = 0 if ZERO_REG and rd_addr[i]==DEPTH-1.
  - Otherwise, if BYPASS and some enabled port matches rd_addr[i], rd_data[i] = that port's wr_data (highest index wins).
  - Otherwise rd_data[i] = mem[rd_addr[i]].
- Zero register: writes to DEPTH-1 are dropped, sb_set to it is dropped, and its pending bit is always 0.
- Scoreboard, one bit per register:
  - sb_set sets pending[sb_addr].
  - Any enabled write clears pending[wr_addr].
  - Set and clear to the same address in the same cycle -> set wins (new producer supersedes).
- rd_pending[i] = pending[rd_addr[i]], forced to 0 when BYPASS and a write to that address is in flight this cycle.
- Reset of outputs: rd_data 0, rd_pending 0, init_done 0 throughout RF_INIT.
- No X may reach rd_data after init_done rises. The bench checks this with ===.

Decomposition:
- Package regfile_pkg:
  - typedef enum logic {RF_INIT, RF_RUN} rf_state_t.
  - Function rf_aw(depth) returning $clog2.
  - Default localparams RF_WIDTH=64, RF_DEPTH=32.
- Sub-module rf_bypass_sel:
  - Parametrised on WIDTH, AW, NWR, ZERO_REG, BYPASS.
  - One instance per read port; performs the zero/bypass/array priority select and the pending mask.
- Top module holds the FSM, storage array, write-conflict resolution and scoreboard.

Test Plan:
1. Reset sweep: rst high 2 cycles then low -> init_done low exactly 32 cycles, then high; all 32 reads return 0 after.
2. Write/read latency: write 0x1234 to r5 on port 0, read r5 next cycle -> 0x1234. Read r5 in the same cycle with BYPASS=1 -> 0x1234; with BYPASS=0 -> old value 0.
3. Write conflict: port 0 writes 0xAAAA and port 1 writes 0xBBBB to r7 in the same cycle -> r7 reads 0xBBBB next cycle.
4. Zero register: write 0xFFFF to r31 -> r31 reads 0 immediately and afterwards; sb_set r31 -> rd_pending 0.
5. Scoreboard: sb_set r3 -> rd_pending=1 next cycle. Write r3 -> same-cycle rd_pending=0 via bypass; bit cleared next cycle. sb_set r3 together with a write to r3 -> pending stays 1.
6. Reset mid-sweep: assert rst at sweep cycle 10 -> sweep restarts, and init_done rises 32 cycles after rst falls.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
//   rf_state_t : sweep/run state of the file
//   rf_aw()    : address width for a given register count
//   RF_WIDTH   : default data width
//   RF_DEPTH   : default register count
package regfile_pkg;

   typedef enum logic {
      RF_INIT,
      RF_RUN
   } rf_state_t;

   localparam int unsigned RF_WIDTH = 64;
   localparam int unsigned RF_DEPTH = 32;

   function automatic int unsigned rf_aw(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/rf_bypass_sel.sv
// Per-read-port operand select: hardwired zero register, then same-cycle write
// forwarding, then the stored array word. Also masks the pending flag when the
// awaited write is arriving this very cycle.
//   en_i         : file is out of its clearing sweep; outputs are 0 otherwise
//   rd_addr_i    : register being read
//   arr_data_i   : stored word at rd_addr_i
//   pending_i    : scoreboard bit at rd_addr_i
//   wr_en_i      : write-port enables (raw, one bit per port)
//   wr_addr_i    : write-port addresses, port j at [j*AW +: AW]
//   wr_data_i    : write-port data, port j at [j*WIDTH +: WIDTH]
//   rd_data_o    : selected operand
//   rd_pending_o : operand still awaits its producer
module rf_bypass_sel #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned AW       = 5,
   parameter int unsigned NWR      = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                 en_i,
   input  logic [AW-1:0]        rd_addr_i,
   input  logic [WIDTH-1:0]     arr_data_i,
   input  logic                 pending_i,
   input  logic [NWR-1:0]       wr_en_i,
   input  logic [NWR*AW-1:0]    wr_addr_i,
   input  logic [NWR*WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0]     rd_data_o,
   output logic                 rd_pending_o
);

   logic             hit;
   logic [WIDTH-1:0] hit_data;

   // Ascending scan so the highest-index matching port is the one that sticks,
   // mirroring which write actually lands in the array.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
            hit      = 1'b1;
            hit_data = wr_data_i[j*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      rd_data_o    = '0;
      rd_pending_o = 1'b0;
      if (!en_i) begin
         rd_data_o    = '0;
         rd_pending_o = 1'b0;
      end else if ((ZERO_REG != 0) && (rd_addr_i == {AW{1'b1}})) begin
         rd_data_o    = '0;
         rd_pending_o = 1'b0;
      end else if ((BYPASS != 0) && hit) begin
         // Producer's data is here now, so the operand is no longer waiting.
         rd_data_o    = hit_data;
         rd_pending_o = 1'b0;
      end else begin
         rd_data_o    = arr_data_i;
         rd_pending_o = pending_i;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port architectural register file with a hardwired zero
// register, write-to-read bypass, per-register pending-write scoreboard and a
// post-reset clearing sweep of the (unreset) storage array.
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset, restarts the sweep
//   rd_addr    : read addresses, port i at [i*AW +: AW]
//   rd_data    : combinational read data, port i at [i*WIDTH +: WIDTH]
//   rd_pending : addressed register awaits a scoreboarded write
//   wr_en      : write enables, one per write port
//   wr_addr    : write addresses, port j at [j*AW +: AW]
//   wr_data    : write data, port j at [j*WIDTH +: WIDTH]
//   sb_set     : mark sb_addr pending (producer issued)
//   sb_addr    : scoreboard address
//   init_done  : high once the clearing sweep has completed
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = RF_WIDTH,
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   localparam int unsigned AW      = rf_aw(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   output logic [NRD-1:0]       rd_pending,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*AW-1:0]    wr_addr,
   input  logic [NWR*WIDTH-1:0] wr_data,
   input  logic                 sb_set,
   input  logic [AW-1:0]        sb_addr,
   output logic                 init_done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   rf_state_t        state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [DEPTH-1:0] pending_q, pending_d;
   logic             run;
   logic [NWR-1:0]   wr_commit;

   // No reset on the array so it can map onto RAM; the sweep does the zeroing.
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign run       = (state_q == RF_RUN);
   assign init_done = run;

   // ---------------------------------------------------------------------------
   // Sweep FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RF_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = RF_RUN;
            end
         end
         RF_RUN: begin
            state_d = RF_RUN;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Write-conflict resolution: a port commits only if no higher-index enabled
   // port targets the same register; writes to the zero register never commit.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int j = 0; j < NWR; j++) begin
         wr_commit[j] = run && !rst && wr_en[j];
         if ((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == LAST_ADDR)) begin
            wr_commit[j] = 1'b0;
         end
         for (int k = j + 1; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == wr_addr[j*AW +: AW])) begin
               wr_commit[j] = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard: writes clear, sb_set sets afterwards so a new producer issued
   // in the same cycle as the old one's writeback stays pending.
   // ---------------------------------------------------------------------------
   always_comb begin
      pending_d = pending_q;
      if (run) begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
               pending_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
         end
         if (sb_set) begin
            pending_d[sb_addr] = 1'b1;
         end
         if (ZERO_REG != 0) begin
            pending_d[LAST_ADDR] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RF_INIT;
         cnt_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == RF_INIT) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_commit[j]) begin
               mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*WIDTH +: WIDTH];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[i*AW +: AW];

      rf_bypass_sel #(
         .WIDTH    (WIDTH),
         .AW       (AW),
         .NWR      (NWR),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_sel (
         .en_i         (run),
         .rd_addr_i    (addr),
         .arr_data_i   (mem_q[addr]),
         .pending_i    (pending_q[addr]),
         .wr_en_i      (wr_en),
         .wr_addr_i    (wr_addr),
         .wr_data_i    (wr_data),
         .rd_data_o    (rd_data[i*WIDTH +: WIDTH]),
         .rd_pending_o (rd_pending[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned NRD   = 2;
   localparam int unsigned NWR   = 2;
   localparam int unsigned AW    = 5;

   logic                 clk;
   logic                 rst;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*WIDTH-1:0] rd_data, rd_data_nb;
   logic [NRD-1:0]       rd_pending, rd_pending_nb;
   logic [NWR-1:0]       wr_en;
   logic [NWR*AW-1:0]    wr_addr;
   logic [NWR*WIDTH-1:0] wr_data;
   logic                 sb_set;
   logic [AW-1:0]        sb_addr;
   logic                 init_done, init_done_nb;

   int checks = 0;
   int errors = 0;

   // Reference model: architectural contents, pending flags, sweep progress.
   logic [WIDTH-1:0] m_mem [DEPTH];
   bit               m_pend [DEPTH];
   bit               m_run  = 1'b0;
   int               m_left = DEPTH;

   regfile_mp #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)
   ) u_dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
      .sb_addr(sb_addr), .init_done(init_done)
   );

   regfile_mp #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)
   ) u_dut_nb (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .rd_pending(rd_pending_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .init_done(init_done_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

   // ------------------------------------------------------------------ model
   function automatic logic [WIDTH-1:0] exp_rd(input int a, input bit byp);
      logic [WIDTH-1:0] v;
      if (!m_run || a == DEPTH - 1) return '0;
      v = m_mem[a];
      if (byp) begin
         for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*WIDTH +: WIDTH];
      end
      return v;
   endfunction

   function automatic bit exp_pend(input int a, input bit byp);
      if (!m_run) return 1'b0;
      if (byp) begin
         for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) return 1'b0;
      end
      return m_pend[a];
   endfunction

   task automatic model_commit();
      int a;
      if (rst) begin
         m_run  = 1'b0;
         m_left = DEPTH;
         foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else if (!m_run) begin
         m_left--;
         if (m_left == 0) begin
            m_run = 1'b1;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
               a = int'(wr_addr[j*AW +: AW]);
               if (a != DEPTH - 1) m_mem[a] = wr_data[j*WIDTH +: WIDTH];
               m_pend[a] = 1'b0;
            end
         end
         if (sb_set && int'(sb_addr) != DEPTH - 1) m_pend[sb_addr] = 1'b1;
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic clk_edge();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      sb_set  = 1'b0;
      sb_addr = '0;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input int a, input logic [WIDTH-1:0] d);
      wr_en[p]               = 1'b1;
      wr_addr[p*AW +: AW]    = AW'(a);
      wr_data[p*WIDTH +: WIDTH] = d;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      int n;
      idle_inputs();
      rd_addr = '0;
      rst = 1'b1;
      clk_edge();
      clk_edge();
      rst = 1'b0;
      #1;
      checks++;
      if (init_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_init_done got %b want 0", init_done);
      end
      // Writes and sb_set during the sweep must be ignored, outputs held at 0.
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
         set_wr(0, $urandom_range(0, DEPTH - 1), {$urandom, $urandom});
         sb_set  = 1'b1;
         sb_addr = AW'($urandom_range(0, DEPTH - 1));
         set_rd(0, int'(wr_addr[0 +: AW]));
         set_rd(1, int'(sb_addr));
         #1;
         checks++;
         if (rd_data !== '0 || rd_pending !== '0) begin
            errors++;
            $display("FAIL sweep_outputs got %h/%b want 0/0", rd_data, rd_pending);
         end
         clk_edge();
         n++;
      end
      idle_inputs();
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL sweep_length got %0d want 32", n);
      end
      for (int i = 0; i < DEPTH / 2; i++) begin
         set_rd(0, i);
         set_rd(1, DEPTH - 1 - i);
         #1;
         checks++;
         if (rd_data !== '0 || rd_pending !== '0 || rd_data_nb !== '0) begin
            errors++;
            $display("FAIL reset_clear r%0d got %h/%b want 0/0", i, rd_data, rd_pending);
         end
         clk_edge();
      end
   endtask

   task automatic test_latency();
      idle_inputs();
      set_wr(0, 5, 64'h1234);
      set_rd(0, 5);
      #1;
      checks++;
      if (rd_data[0 +: WIDTH] !== 64'h1234) begin
         errors++;
         $display("FAIL latency_bypass got %h want 1234", rd_data[0 +: WIDTH]);
      end
      checks++;
      if (rd_data_nb[0 +: WIDTH] !== 64'h0) begin
         errors++;
         $display("FAIL latency_nobypass got %h want 0", rd_data_nb[0 +: WIDTH]);
      end
      clk_edge();
      idle_inputs();
      #1;
      checks++;
      if (rd_data[0 +: WIDTH] !== 64'h1234 || rd_data_nb[0 +: WIDTH] !== 64'h1234) begin
         errors++;
         $display("FAIL latency_next got %h/%h want 1234", rd_data[0 +: WIDTH],
                  rd_data_nb[0 +: WIDTH]);
      end
   endtask

   task automatic test_conflict();
      idle_inputs();
      set_wr(0, 7, 64'hAAAA);
      set_wr(1, 7, 64'hBBBB);
      set_rd(1, 7);
      #1;
      checks++;
      if (rd_data[WIDTH +: WIDTH] !== 64'hBBBB) begin
         errors++;
         $display("FAIL conflict_bypass got %h want bbbb", rd_data[WIDTH +: WIDTH]);
      end
      clk_edge();
      idle_inputs();
      #1;
      checks++;
      if (rd_data[WIDTH +: WIDTH] !== 64'hBBBB || rd_data_nb[WIDTH +: WIDTH] !== 64'hBBBB) begin
         errors++;
         $display("FAIL conflict_commit got %h/%h want bbbb", rd_data[WIDTH +: WIDTH],
                  rd_data_nb[WIDTH +: WIDTH]);
      end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      set_wr(0, 31, 64'hFFFF);
      sb_set  = 1'b1;
      sb_addr = 5'd31;
      set_rd(0, 31);
      #1;
      checks++;
      if (rd_data[0 +: WIDTH] !== 64'h0 || rd_data_nb[0 +: WIDTH] !== 64'h0) begin
         errors++;
         $display("FAIL zero_same_cycle got %h/%h want 0", rd_data[0 +: WIDTH],
                  rd_data_nb[0 +: WIDTH]);
      end
      clk_edge();
      idle_inputs();
      #1;
      checks++;
      if (rd_data[0 +: WIDTH] !== 64'h0 || rd_data_nb[0 +: WIDTH] !== 64'h0 ||
          rd_pending[0] !== 1'b0 || rd_pending_nb[0] !== 1'b0) begin
         errors++;
         $display("FAIL zero_after got %h/%b want 0/0", rd_data[0 +: WIDTH], rd_pending[0]);
      end
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      sb_set  = 1'b1;
      sb_addr = 5'd3;
      set_rd(0, 3);
      clk_edge();
      idle_inputs();
      #1;
      checks++;
      if (rd_pending[0] !== 1'b1 || rd_pending_nb[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_set got %b/%b want 1", rd_pending[0], rd_pending_nb[0]);
      end
      set_wr(1, 3, 64'h33);
      #1;
      checks++;
      if (rd_pending[0] !== 1'b0 || rd_pending_nb[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_bypass_mask got %b/%b want 0/1", rd_pending[0], rd_pending_nb[0]);
      end
      clk_edge();
      idle_inputs();
      #1;
      checks++;
      if (rd_pending[0] !== 1'b0 || rd_pending_nb[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_clear got %b/%b want 0", rd_pending[0], rd_pending_nb[0]);
      end
      set_wr(0, 3, 64'h44);
      sb_set  = 1'b1;
      sb_addr = 5'd3;
      clk_edge();
      idle_inputs();
      #1;
      checks++;
      if (rd_pending[0] !== 1'b1 || rd_data[0 +: WIDTH] !== 64'h44) begin
         errors++;
         $display("FAIL sb_set_wins got %b/%h want 1/44", rd_pending[0], rd_data[0 +: WIDTH]);
      end
      set_wr(0, 3, 64'h55);
      clk_edge();
      idle_inputs();
   endtask

   task automatic test_random();
      int a;
      for (int c = 0; c < 300; c++) begin
         idle_inputs();
         for (int j = 0; j < NWR; j++) begin
            if ($urandom_range(0, 1) == 1) begin
               a = ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 7);
               set_wr(j, a, {$urandom, $urandom});
            end
         end
         sb_set  = 1'($urandom_range(0, 1));
         sb_addr = AW'(($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 7));
         for (int p = 0; p < NRD; p++)
            set_rd(p, ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 7));
         #1;
         checks++;
         if (init_done !== m_run) begin
            errors++;
            $display("FAIL rand_init_done got %b want %b", init_done, m_run);
         end
         for (int p = 0; p < NRD; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            checks++;
            if (rd_data[p*WIDTH +: WIDTH] !== exp_rd(a, 1'b1) ||
                rd_pending[p] !== exp_pend(a, 1'b1)) begin
               errors++;
               $display("FAIL rand_byp p%0d r%0d got %h/%b want %h/%b", p, a,
                        rd_data[p*WIDTH +: WIDTH], rd_pending[p], exp_rd(a, 1'b1),
                        exp_pend(a, 1'b1));
            end
            checks++;
            if (rd_data_nb[p*WIDTH +: WIDTH] !== exp_rd(a, 1'b0) ||
                rd_pending_nb[p] !== exp_pend(a, 1'b0)) begin
               errors++;
               $display("FAIL rand_nobyp p%0d r%0d got %h/%b want %h/%b", p, a,
                        rd_data_nb[p*WIDTH +: WIDTH], rd_pending_nb[p], exp_rd(a, 1'b0),
                        exp_pend(a, 1'b0));
            end
         end
         clk_edge();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      int n;
      idle_inputs();
      rst = 1'b1;
      clk_edge();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) clk_edge();
      checks++;
      if (init_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_sweep_done got %b want 0", init_done);
      end
      rst = 1'b1;
      clk_edge();
      rst = 1'b0;
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
         clk_edge();
         n++;
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL restart_length got %0d want 32", n);
      end
      for (int i = 0; i < DEPTH / 2; i++) begin
         set_rd(0, i);
         set_rd(1, DEPTH - 1 - i);
         #1;
         checks++;
         if (rd_data !== '0 || rd_pending !== '0 || rd_data_nb !== '0) begin
            errors++;
            $display("FAIL restart_clear r%0d got %h/%b want 0/0", i, rd_data, rd_pending);
         end
         clk_edge();
      end
   endtask

   initial begin
      rst     = 1'b1;
      rd_addr = '0;
      idle_inputs();
      test_reset();
      test_latency();
      test_conflict();
      test_zero_reg();
      test_scoreboard();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
